// File: rtl/fp_muldiv_seq_if.sv
// fp_muldiv_seq_if: operand and result handshake bundle for fp_muldiv_seq.
// master drives operands and out_ready; slave is the arithmetic unit.
interface fp_muldiv_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_div;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_of;
  logic         flag_uf;
  logic         flag_dz;

  modport master (
    output in_valid, op_div, x, y, out_ready,
    input  in_ready, out_valid, result,
    input  flag_of, flag_uf, flag_dz
  );

  modport slave (
    input  in_valid, op_div, x, y, out_ready,
    output in_ready, out_valid, result,
    output flag_of, flag_uf, flag_dz
  );
endinterface

// File: rtl/fp_muldiv_seq.sv
// fp_muldiv_seq: iterative FP mul (shift-add) / div (restoring), one bit per cycle.
// Define FP_MULDIV_RNE_EN for round-to-nearest-even; default build truncates.
module fp_muldiv_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  fp_muldiv_seq_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 4);
  localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);
  localparam logic [CW-1:0] MUL_LAST = CW'(MAN_W);
  localparam logic [CW-1:0] DIV_LAST = CW'(MAN_W + 2);
`ifdef FP_MULDIV_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, CHECK, ITER, NORM, ROUND, DONE
  } state_e;

  state_e state_q, state_d;

  logic [W-2:0]         x_q, x_d, y_q, y_d;
  logic [W-1:0]         res_q, res_d;
  logic                 div_q, div_d;
  logic                 sign_q, sign_d;
  logic                 spec_q, spec_d;
  logic                 of_q, of_d;
  logic                 uf_q, uf_d;
  logic                 dz_q, dz_d;
  logic [2*M-1:0]       acc_q, acc_d;
  logic [2*M-1:0]       a_q, a_d;
  logic [M-1:0]         b_q, b_d;
  logic [M:0]           r_q, r_d;
  logic [MAN_W-1:0]     man_q, man_d;
  logic                 g_q, g_d;
  logic                 s_q, s_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [EXP_W-1:0]     ex, ey;
  logic signed [EW-1:0] exs, eys;
  logic [M-1:0]         mx, my;
  logic                 xz, yz;
  logic                 r_ge;
  logic [M:0]           r_sub;
  logic                 rnd_up, carry;
  logic [MAN_W-1:0]     frac_fin;
  logic signed [EW-1:0] e_fin;

  assign ex  = x_q[W-2 -: EXP_W];
  assign ey  = y_q[W-2 -: EXP_W];
  assign exs = {2'b00, ex};
  assign eys = {2'b00, ey};
  assign mx  = {1'b1, x_q[MAN_W-1:0]};
  assign my  = {1'b1, y_q[MAN_W-1:0]};
  assign xz  = (ex == '0);
  assign yz  = (ey == '0);

  assign r_ge  = (r_q >= {1'b0, my});
  assign r_sub = r_ge ? r_q - {1'b0, my} : r_q;

  assign rnd_up = RNE & g_q & (s_q | man_q[0]);
  assign {carry, frac_fin} = {1'b0, man_q} + {{MAN_W{1'b0}}, rnd_up};
  assign e_fin = e_q + (carry ? ONE : ZERO);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    div_d   = div_q;
    sign_d  = sign_q;
    spec_d  = spec_q;
    of_d    = of_q;
    uf_d    = uf_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    man_d   = man_q;
    g_d     = g_q;
    s_d     = s_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          x_d     = io.x[W-2:0];
          y_d     = io.y[W-2:0];
          div_d   = io.op_div;
          sign_d  = io.x[W-1] ^ io.y[W-1];
          of_d    = 1'b0;
          uf_d    = 1'b0;
          dz_d    = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        spec_d = xz | yz;
        e_d    = div_q ? exs - eys + BIAS : exs + eys - BIAS;
        a_d    = {{M{1'b0}}, mx};
        b_d    = my;
        r_d    = {1'b0, mx};
        acc_d  = '0;
        cnt_d  = '0;
        if (xz) begin
          res_d = {sign_q, {(W-1){1'b0}}};
          dz_d  = div_q & yz;
        end else if (yz && div_q) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          dz_d  = 1'b1;
        end else if (yz) begin
          res_d = {sign_q, {(W-1){1'b0}}};
        end
        // specials ride through ROUND untouched, giving them a 2-cycle path
        state_d = (xz | yz) ? ROUND : ITER;
      end
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          r_d   = r_sub << 1;
          acc_d = {acc_q[2*M-2:0], r_ge};
          if (cnt_q == DIV_LAST) state_d = NORM;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
          if (cnt_q == MUL_LAST) state_d = NORM;
        end
      end
      NORM: begin
        if (div_q) begin
          if (acc_q[M+1]) begin
            man_d = acc_q[M:2];
            g_d   = acc_q[1];
            s_d   = acc_q[0] | (r_q != '0);
          end else begin
            man_d = acc_q[M-1:1];
            g_d   = acc_q[0];
            s_d   = (r_q != '0);
            e_d   = e_q - ONE;
          end
        end else begin
          if (acc_q[2*M-1]) begin
            man_d = acc_q[2*M-2:M];
            g_d   = acc_q[M-1];
            s_d   = |acc_q[M-2:0];
            e_d   = e_q + ONE;
          end else begin
            man_d = acc_q[2*M-3:M-1];
            g_d   = acc_q[M-2];
            s_d   = |acc_q[M-3:0];
          end
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (!spec_q) begin
          if (e_fin >= EMAX) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_d  = 1'b1;
          end else if (e_fin[EW-1] || e_fin == ZERO) begin
            res_d = {sign_q, {(W-1){1'b0}}};
            uf_d  = 1'b1;
          end else begin
            res_d = {sign_q, e_fin[EXP_W-1:0], frac_fin};
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
      div_q  <= 1'b0;
      sign_q <= 1'b0;
      spec_q <= 1'b0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
      dz_q   <= 1'b0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      man_q  <= '0;
      g_q    <= 1'b0;
      s_q    <= 1'b0;
      e_q    <= '0;
      cnt_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      res_q  <= res_d;
      div_q  <= div_d;
      sign_q <= sign_d;
      spec_q <= spec_d;
      of_q   <= of_d;
      uf_q   <= uf_d;
      dz_q   <= dz_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      man_q  <= man_d;
      g_q    <= g_d;
      s_q    <= s_d;
      e_q    <= e_d;
      cnt_q  <= cnt_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = res_q;
  assign io.flag_of   = of_q;
  assign io.flag_uf   = uf_q;
  assign io.flag_dz   = dz_q;
endmodule

// File: tb/tb_fp_muldiv_seq.sv
// tb_fp_muldiv_seq: directed binary16 vectors for fp_muldiv_seq.
// Expected values are hand-derived; rounding cases follow FP_MULDIV_RNE_EN.
module tb_fp_muldiv_seq;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  fp_muldiv_seq_if #(.EXP_W(5), .MAN_W(10)) bus ();

  fp_muldiv_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic [2:0] f, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bus.op_div   = op;
    bus.x        = a;
    bus.y        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) lat = -1;
    r = bus.result;
    f = {bus.flag_of, bus.flag_uf, bus.flag_dz};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_div    = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_hs got %b want 10", {bus.in_ready, bus.out_valid});
    end
    vectors++;
    if ({bus.result, bus.flag_of, bus.flag_uf, bus.flag_dz} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_out got %h want 0",
               {bus.result, bus.flag_of, bus.flag_uf, bus.flag_dz});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors(input string tag, input logic op,
                              input logic [15:0] xs [], input logic [15:0] ys [],
                              input logic [15:0] rs [], input logic [2:0] fs [],
                              input int ls []);
    logic [15:0] r;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < xs.size(); i++) begin
      run_op(op, xs[i], ys[i], r, f, lat);
      vectors++;
      if (r !== rs[i]) begin
        miscompares++;
        $display("FAIL %s[%0d] result got %h want %h", tag, i, r, rs[i]);
      end
      vectors++;
      if (f !== fs[i]) begin
        miscompares++;
        $display("FAIL %s[%0d] flags(of,uf,dz) got %b want %b", tag, i, f, fs[i]);
      end
      vectors++;
      if (lat !== ls[i]) begin
        miscompares++;
        $display("FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, ls[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] xs [] = '{16'h3E00, 16'hC200, 16'h3E00, 16'h7800,
                           16'h0400, 16'h0000, 16'h4000};
    logic [15:0] ys [] = '{16'h4000, 16'h3C00, 16'h3E00, 16'h4000,
                           16'h3800, 16'hC000, 16'h0000};
    logic [15:0] rs [] = '{16'h4200, 16'hC200, 16'h4080, 16'h7C00,
                           16'h0000, 16'h8000, 16'h0000};
    logic [2:0]  fs [] = '{3'b000, 3'b000, 3'b000, 3'b100,
                           3'b010, 3'b000, 3'b000};
    int          ls [] = '{14, 14, 14, 14, 14, 2, 2};
    test_vectors("mul", 1'b0, xs, ys, rs, fs, ls);
  endtask

  task automatic test_div();
    logic [15:0] xs [] = '{16'h3C00, 16'h4400, 16'hBC00, 16'h0000};
    logic [15:0] ys [] = '{16'h4200, 16'h4000, 16'h0000, 16'h0000};
    logic [15:0] rs [] = '{16'h3555, 16'h4000, 16'hFC00, 16'h0000};
    logic [2:0]  fs [] = '{3'b000, 3'b000, 3'b001, 3'b001};
    int          ls [] = '{16, 16, 2, 2};
    test_vectors("div", 1'b1, xs, ys, rs, fs, ls);
  endtask

  task automatic test_round();
    logic [15:0] xs [] = '{16'h3E01, 16'h3DA8};
    logic [15:0] ys [] = '{16'h3C01, 16'h3DA8};
`ifdef FP_MULDIV_RNE_EN
    logic [15:0] rs [] = '{16'h3E03, 16'h4000};
`else
    logic [15:0] rs [] = '{16'h3E02, 16'h3FFF};
`endif
    logic [2:0]  fs [] = '{3'b000, 3'b000};
    int          ls [] = '{14, 14};
    test_vectors("round", 1'b0, xs, ys, rs, fs, ls);
  endtask

  task automatic test_backpressure();
    int n;
    bus.op_div   = 1'b0;
    bus.x        = 16'h3E00;
    bus.y        = 16'h4000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.x = 16'h4400;
    bus.y = 16'h4400;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== 14) begin
      miscompares++;
      $display("FAIL bp_latency got %0d want 14", n);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b10, 16'h4200}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b res=%h want v=1 r=0 res=4200",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_release got %b want 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat;
    bus.op_div   = 1'b0;
    bus.x        = 16'h3E00;
    bus.y        = 16'h4000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b01, 16'h0000}) begin
      miscompares++;
      $display("FAIL rst_iter got v=%b r=%b res=%h want v=0 r=1 res=0000",
               bus.out_valid, bus.in_ready, bus.result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 16'h3C00, 16'h4200, r, f, lat);
    vectors++;
    if ({r, f} !== {16'h3555, 3'b000}) begin
      miscompares++;
      $display("FAIL rst_after got %h/%b want 3555/000", r, f);
    end
    vectors++;
    if (lat !== 16) begin
      miscompares++;
      $display("FAIL rst_after_lat got %0d want 16", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat;
    run_op(1'b0, 16'h7800, 16'h4000, r, f, lat);
    vectors++;
    if ({r, f} !== {16'h7C00, 3'b100}) begin
      miscompares++;
      $display("FAIL b2b_of got %h/%b want 7C00/100", r, f);
    end
    run_op(1'b1, 16'h4400, 16'h4000, r, f, lat);
    vectors++;
    if ({r, f} !== {16'h4000, 3'b000}) begin
      miscompares++;
      $display("FAIL b2b_clear got %h/%b want 4000/000", r, f);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_div();
    test_round();
    test_backpressure();
    test_reset_mid_iter();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
